// File: rtl/enc_job_sched_if.sv
// Purpose: bundles the scheduler's requester, encoder and response signals.
//   master : scheduler side (drives grants, encoder controls, response, status)
//   slave  : environment side (drives requests, sched_en, enc_done, rsp_ready)
//   sched_en/req      -> grant enable and per-requester level requests
//   gnt/sel_id        <- one-hot grant and id driving the level-HV mux
//   enc_en/enc_start  <- encoder enable and one-cycle start pulse
//   enc_done          -> encoder completion
//   rsp_*             <- response handshake (rsp_ready from requester)
//   busy/job_count    <- status
interface enc_job_sched_if #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ID_W    = 1,
    parameter int unsigned CNT_W   = 16
);
    logic               sched_en;
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    sel_id;
    logic               enc_en;
    logic               enc_start;
    logic               enc_done;
    logic               rsp_valid;
    logic [ID_W-1:0]    rsp_id;
    logic               rsp_timeout;
    logic               rsp_ready;
    logic               busy;
    logic [CNT_W-1:0]   job_count;

    modport master (
        input  sched_en, req, enc_done, rsp_ready,
        output gnt, sel_id, enc_en, enc_start, rsp_valid, rsp_id, rsp_timeout, busy, job_count
    );

    modport slave (
        output sched_en, req, enc_done, rsp_ready,
        input  gnt, sel_id, enc_en, enc_start, rsp_valid, rsp_id, rsp_timeout, busy, job_count
    );
endinterface

// File: rtl/enc_job_sched.sv
// Purpose: round-robin scheduler sharing one encoding datapath among NUM_REQ requesters.
//   Grants one requester, pulses enc_start, waits for enc_done or a timeout, then returns a
//   response over a valid/ready handshake before granting again.
// Ports:
//   clk  - rising-edge clock
//   nrst - synchronous, active-high reset
//   bus  - enc_job_sched_if master modport (requests, grant, encoder control, response, status)
module enc_job_sched #(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned ID_W       = 1,
    parameter int unsigned TIMEOUT_CC = 64,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             nrst,
    enc_job_sched_if.master  bus
);
    localparam int unsigned TMR_W = $clog2(TIMEOUT_CC);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [ID_W-1:0]    sel_id_q, sel_id_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
    logic               rsp_timeout_q, rsp_timeout_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [CNT_W-1:0]   job_count_q, job_count_d;
    logic               enc_en_q, enc_en_d;
    logic               enc_start_q, enc_start_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               busy_q, busy_d;

    logic               found;
    logic [ID_W-1:0]    pick;
    int unsigned        idx;

    // Round-robin search starting just after the last served requester.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = 32'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && bus.req[ID_W'(idx)]) begin
                found = 1'b1;
                pick  = ID_W'(idx);
            end
        end
    end

    // Next-state and registered-output logic; status outputs follow the next state.
    always_comb begin
        state_d       = state_q;
        gnt_d         = gnt_q;
        sel_id_d      = sel_id_q;
        rr_ptr_d      = rr_ptr_q;
        rsp_id_d      = rsp_id_q;
        rsp_timeout_d = rsp_timeout_q;
        timer_d       = timer_q;
        job_count_d   = job_count_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.sched_en && found) begin
                    gnt_d    = NUM_REQ'(1) << pick;
                    sel_id_d = pick;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                timer_d = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                timer_d = timer_q + TMR_W'(1);
                // done has priority over a timeout on the same cycle
                if (bus.enc_done) begin
                    rsp_timeout_d = 1'b0;
                    rsp_id_d      = sel_id_q;
                    state_d       = ST_RESP;
                end else if (timer_q == TMR_W'(TIMEOUT_CC - 1)) begin
                    rsp_timeout_d = 1'b1;
                    rsp_id_d      = sel_id_q;
                    state_d       = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_valid_q && bus.rsp_ready) begin
                    rr_ptr_d = sel_id_q;
                    if (!rsp_timeout_q && (job_count_q != '1)) begin
                        job_count_d = job_count_q + CNT_W'(1);
                    end
                    gnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        enc_start_d = (state_d == ST_START);
        enc_en_d    = (state_d == ST_START) || (state_d == ST_WAIT);
        rsp_valid_d = (state_d == ST_RESP);
        busy_d      = (state_d != ST_IDLE);
    end

    // State and output registers; reset abandons any job in flight.
    always_ff @(posedge clk) begin
        if (nrst) begin
            state_q       <= ST_IDLE;
            gnt_q         <= '0;
            sel_id_q      <= '0;
            rr_ptr_q      <= ID_W'(NUM_REQ - 1);
            rsp_id_q      <= '0;
            rsp_timeout_q <= 1'b0;
            timer_q       <= '0;
            job_count_q   <= '0;
            enc_en_q      <= 1'b0;
            enc_start_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            gnt_q         <= gnt_d;
            sel_id_q      <= sel_id_d;
            rr_ptr_q      <= rr_ptr_d;
            rsp_id_q      <= rsp_id_d;
            rsp_timeout_q <= rsp_timeout_d;
            timer_q       <= timer_d;
            job_count_q   <= job_count_d;
            enc_en_q      <= enc_en_d;
            enc_start_q   <= enc_start_d;
            rsp_valid_q   <= rsp_valid_d;
            busy_q        <= busy_d;
        end
    end

    assign bus.gnt         = gnt_q;
    assign bus.sel_id      = sel_id_q;
    assign bus.enc_en      = enc_en_q;
    assign bus.enc_start   = enc_start_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_id      = rsp_id_q;
    assign bus.rsp_timeout = rsp_timeout_q;
    assign bus.busy        = busy_q;
    assign bus.job_count   = job_count_q;
endmodule
